// File: rtl/store_buffer.sv
// Posted-write store buffer for the MEM stage.
// Stores are queued in a circular FIFO and drained in order whenever the
// shared memory port is granted. Loads are served from the youngest matching
// buffered store, or from data_mem when nothing in the buffer matches.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic          ld_valid,
  output logic [DW-1:0] ld_data,
  output logic          empty,
  input  logic          d_gnt,
  output logic          d_we,
  output logic [AW-1:0] d_addr,
  output logic [DW-1:0] d_dataout,
  input  logic [DW-1:0] d_datain
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          hit;
  logic [PW-1:0] hit_idx;
  logic          is_load;
  logic          is_store;
  logic          load_miss;
  logic          pop;
  logic          full;
  logic          coalesce;
  logic          enq;
  logic          ld_done;

  // Youngest-match search: walk oldest to youngest so the last hit wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count && addr_q[rd_ptr + PW'(i)] == req_addr) begin
        hit     = 1'b1;
        hit_idx = rd_ptr + PW'(i);
      end
    end
  end

  // Request classification, drain decision and stall generation.
  always_comb begin
    is_load   = req_valid & ~req_we;
    is_store  = req_valid & req_we;
    full      = (count == CW'(DEPTH));
    load_miss = is_load & ~hit;
    // A missing load owns the port this cycle; a hitting load does not.
    pop       = d_gnt & (count != '0) & ~load_miss;
    // The head being popped cannot absorb new data: it is leaving now.
    coalesce  = is_store & hit & ~(pop & (hit_idx == rd_ptr));
    enq       = is_store & ~coalesce & (~full | pop);
    ld_done   = is_load & (hit | d_gnt);
    stall     = (is_store & ~coalesce & full & ~pop) | (load_miss & ~d_gnt);
  end

  // Memory port mux: load miss first, then head drain, otherwise quiet.
  always_comb begin
    d_we      = 1'b0;
    d_addr    = '0;
    d_dataout = '0;
    if (load_miss && d_gnt) begin
      d_addr = req_addr;
    end else if (pop) begin
      d_we      = 1'b1;
      d_addr    = addr_q[rd_ptr];
      d_dataout = data_q[rd_ptr];
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage: enqueue at the tail or overwrite a coalescing entry.
  always_ff @(posedge clock) begin
    // NOTE: the entry array has no reset; count gates every read, so stale
    // contents are never observed and the array can map onto plain flops/RAM.
    if (coalesce) data_q[hit_idx] <= req_wdata;
    if (enq) begin
      addr_q[wr_ptr] <= req_addr;
      data_q[wr_ptr] <= req_wdata;
    end
  end

  // Registered load result, one cycle after the load is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_valid <= 1'b0;
      ld_data  <= '0;
    end else begin
      ld_valid <= ld_done;
      if (ld_done) ld_data <= hit ? data_q[hit_idx] : d_datain;
    end
  end

  assign empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural data_mem model.
module tb_store_buffer;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        stall;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        empty;
  logic        d_gnt;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic [15:0] d_datain;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];
  logic [7:0]  wlog_a [$];
  logic [15:0] wlog_d [$];

  store_buffer #(.DEPTH(4), .AW(8), .DW(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .empty     (empty),
    .d_gnt     (d_gnt),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_dataout (d_dataout),
    .d_datain  (d_datain)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // data_mem: combinational read, write on the rising edge, write log kept.
  assign d_datain = mem[d_addr];
  always @(posedge clock) begin
    if (d_we) begin
      mem[d_addr] <= d_dataout;
      wlog_a.push_back(d_addr);
      wlog_d.push_back(d_dataout);
    end
  end

  typedef struct {
    logic        v;
    logic        we;
    logic [7:0]  a;
    logic [15:0] wd;
    logic        gnt;
    logic        e_stall;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_dout;
    logic        e_ldv;
    logic [15:0] e_ldd;
    logic        e_empty;
  } vec_t;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic we, input logic [7:0] a,
                              input logic [15:0] wd, input logic gnt, input logic s,
                              input logic w, input logic [7:0] ea, input logic [15:0] ed,
                              input logic lv, input logic [15:0] ld, input logic em);
    vec_t r;
    r.v = v; r.we = we; r.a = a; r.wd = wd; r.gnt = gnt;
    r.e_stall = s; r.e_we = w; r.e_addr = ea; r.e_dout = ed;
    r.e_ldv = lv; r.e_ldd = ld; r.e_empty = em;
    return r;
  endfunction

  // One cycle: drive at the falling edge, check the port before the rising
  // edge, then check registered outputs just after it.
  task automatic cyc(input string tag, input vec_t t);
    @(negedge clock);
    req_valid = t.v;
    req_we    = t.we;
    req_addr  = t.a;
    req_wdata = t.wd;
    d_gnt     = t.gnt;
    #1;
    check({tag, " stall"},     {31'd0, stall}, {31'd0, t.e_stall});
    check({tag, " d_we"},      {31'd0, d_we},  {31'd0, t.e_we});
    check({tag, " d_addr"},    {24'd0, d_addr}, {24'd0, t.e_addr});
    check({tag, " d_dataout"}, {16'd0, d_dataout}, {16'd0, t.e_dout});
    @(posedge clock);
    #1;
    check({tag, " ld_valid"},  {31'd0, ld_valid}, {31'd0, t.e_ldv});
    if (t.e_ldv) check({tag, " ld_data"}, {16'd0, ld_data}, {16'd0, t.e_ldd});
    check({tag, " empty"},     {31'd0, empty}, {31'd0, t.e_empty});
  endtask

  vec_t vecs [24];
  logic [7:0]  exp_a [10];
  logic [15:0] exp_d [10];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h003C + 16'(i);

    // Tests 2, 3, 4 and 6 as one continuous stream.
    //                  v  we  addr   wdata     gnt stall we  d_addr d_dout    ldv ld_data   empty
    vecs[0]  = mk(H, H, 8'h03, 16'hc369, H,  L, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[1]  = mk(L, L, 8'h00, 16'h0000, H,  L, H, 8'h03, 16'hc369, L, 16'h0000, H);
    vecs[2]  = mk(H, H, 8'h00, 16'h0010, L,  L, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[3]  = mk(H, H, 8'h01, 16'h0011, L,  L, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[4]  = mk(H, H, 8'h02, 16'h0012, L,  L, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[5]  = mk(H, H, 8'h03, 16'h0013, L,  L, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[6]  = mk(H, H, 8'h07, 16'h0077, L,  H, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[7]  = mk(H, H, 8'h07, 16'h0077, L,  H, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[8]  = mk(H, H, 8'h02, 16'h0099, L,  L, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[9]  = mk(H, H, 8'h07, 16'h0077, H,  L, H, 8'h00, 16'h0010, L, 16'h0000, L);
    vecs[10] = mk(L, L, 8'h00, 16'h0000, H,  L, H, 8'h01, 16'h0011, L, 16'h0000, L);
    vecs[11] = mk(L, L, 8'h00, 16'h0000, H,  L, H, 8'h02, 16'h0099, L, 16'h0000, L);
    vecs[12] = mk(L, L, 8'h00, 16'h0000, H,  L, H, 8'h03, 16'h0013, L, 16'h0000, L);
    vecs[13] = mk(L, L, 8'h00, 16'h0000, H,  L, H, 8'h07, 16'h0077, L, 16'h0000, H);
    vecs[14] = mk(L, L, 8'h00, 16'h0000, H,  L, L, 8'h00, 16'h0000, L, 16'h0000, H);
    vecs[15] = mk(H, L, 8'h05, 16'h0000, L,  H, L, 8'h00, 16'h0000, L, 16'h0000, H);
    vecs[16] = mk(H, L, 8'h05, 16'h0000, H,  L, L, 8'h05, 16'h0000, H, 16'h0041, H);
    vecs[17] = mk(L, L, 8'h00, 16'h0000, H,  L, L, 8'h00, 16'h0000, L, 16'h0000, H);
    vecs[18] = mk(H, H, 8'h06, 16'h0666, L,  L, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[19] = mk(H, H, 8'h08, 16'h0888, L,  L, L, 8'h00, 16'h0000, L, 16'h0000, L);
    vecs[20] = mk(H, L, 8'h06, 16'h0000, H,  L, H, 8'h06, 16'h0666, H, 16'h0666, L);
    vecs[21] = mk(H, L, 8'h08, 16'h0000, L,  L, L, 8'h00, 16'h0000, H, 16'h0888, L);
    vecs[22] = mk(H, L, 8'h03, 16'h0000, H,  L, L, 8'h03, 16'h0000, H, 16'h0013, L);
    vecs[23] = mk(L, L, 8'h00, 16'h0000, H,  L, H, 8'h08, 16'h0888, L, 16'h0000, H);

    exp_a = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h07, 8'h06, 8'h08, 8'h04, 8'h04};
    exp_d = '{16'hc369, 16'h0010, 16'h0011, 16'h0099, 16'h0013, 16'h0077,
              16'h0666, 16'h0888, 16'h00AA, 16'h00BB};

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    d_gnt     = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset empty",     {31'd0, empty},    32'd1);
    check("reset stall",     {31'd0, stall},    32'd0);
    check("reset d_we",      {31'd0, d_we},     32'd0);
    check("reset ld_valid",  {31'd0, ld_valid}, 32'd0);
    check("reset ld_data",   {16'd0, ld_data},  32'd0);
    check("reset d_addr",    {24'd0, d_addr},   32'd0);
    check("reset d_dataout", {16'd0, d_dataout}, 32'd0);

    // Test 1: reset asserted mid-drain with three stores pending.
    cyc("t1 st20", mk(H, H, 8'h20, 16'h00A0, L, L, L, 8'h00, 16'h0000, L, 16'h0000, L));
    cyc("t1 st21", mk(H, H, 8'h21, 16'h00A1, L, L, L, 8'h00, 16'h0000, L, 16'h0000, L));
    cyc("t1 st22", mk(H, H, 8'h22, 16'h00A2, L, L, L, 8'h00, 16'h0000, L, 16'h0000, L));
    @(negedge clock);
    req_valid = 1'b0;
    d_gnt     = 1'b1;
    #1;
    check("t1 drain d_we",   {31'd0, d_we},   32'd1);
    check("t1 drain d_addr", {24'd0, d_addr}, 32'h20);
    #1;
    reset = 1'b0;
    #1;
    check("t1 in-reset d_we",     {31'd0, d_we},     32'd0);
    check("t1 in-reset empty",    {31'd0, empty},    32'd1);
    check("t1 in-reset stall",    {31'd0, stall},    32'd0);
    check("t1 in-reset ld_valid", {31'd0, ld_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc("t1 post0", mk(L, L, 8'h00, 16'h0000, H, L, L, 8'h00, 16'h0000, L, 16'h0000, H));
    cyc("t1 post1", mk(L, L, 8'h00, 16'h0000, H, L, L, 8'h00, 16'h0000, L, 16'h0000, H));
    for (int i = 0; i < 3; i++)
      check($sformatf("t1 mem[%0h] untouched", 8'h20 + i), {16'd0, mem[8'h20 + i]},
            {16'd0, 16'h003C + 16'h0020 + 16'(i)});

    // Tests 2, 3, 4, 6 from the table.
    for (int i = 0; i < 24; i++) cyc($sformatf("v%0d", i), vecs[i]);

    // Test 5: store to the address of a head entry that drains this cycle.
    cyc("t5 stA",  mk(H, H, 8'h04, 16'h00AA, L, L, L, 8'h00, 16'h0000, L, 16'h0000, L));
    cyc("t5 stB",  mk(H, H, 8'h04, 16'h00BB, H, L, H, 8'h04, 16'h00AA, L, 16'h0000, L));
    cyc("t5 ld4",  mk(H, L, 8'h04, 16'h0000, L, L, L, 8'h00, 16'h0000, H, 16'h00BB, L));
    cyc("t5 drn",  mk(L, L, 8'h00, 16'h0000, H, L, H, 8'h04, 16'h00BB, L, 16'h0000, H));
    cyc("t5 idle", mk(L, L, 8'h00, 16'h0000, H, L, L, 8'h00, 16'h0000, L, 16'h0000, H));

    // Whole-run drain order and data as seen by data_mem.
    check("write count", wlog_a.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < wlog_a.size()) begin
        check($sformatf("write%0d addr", i), {24'd0, wlog_a[i]}, {24'd0, exp_a[i]});
        check($sformatf("write%0d data", i), {16'd0, wlog_d[i]}, {16'd0, exp_d[i]});
      end
    end
    check("mem[4] final", {16'd0, mem[4]}, 32'h00BB);
    check("mem[5] final", {16'd0, mem[5]}, 32'h0041);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
